// File: rtl/apb_slave_regfile.sv
// APB completer backed by a word-addressed register file.
// Programmable wait states; bad addresses answer with PSLVERR.
module apb_slave_regfile #(
  parameter int          SLAVE_SEL   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [2:0]  PSELX,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] SEL_MASK = 3'(1 << SLAVE_SEL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic          wr;
  logic          err;
  logic [31:0]   wdata;
  logic [31:0]   mem [DEPTH];

  logic          sel;
  logic          addr_err;
  logic [AW-1:0] cur_idx;
  logic          cur_wr;
  logic          cur_err;

  // masking keeps every select bit referenced; only our bit matters
  assign sel = |(PSELX & SEL_MASK);

  assign addr_err = (PADDR[1:0] != 2'b00) ||
                    (PADDR[31:AW+2] != BASE_ADDR[31:AW+2]);

  // with zero wait states READY is entered straight from the setup edge
  always_comb begin
    cur_idx = idx;
    cur_wr  = wr;
    cur_err = err;
    if (state == S_IDLE) begin
      cur_idx = PADDR[AW+1:2];
      cur_wr  = PWRITE;
      cur_err = addr_err;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      wr      <= 1'b0;
      err     <= 1'b0;
      wdata   <= '0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      mem     <= '{default: '0};
    end else begin
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel && !PENABLE) begin
            idx   <= PADDR[AW+1:2];
            wr    <= PWRITE;
            err   <= addr_err;
            wdata <= PWDATA;
            if (WAIT_STATES == 0) begin
              state   <= S_READY;
              PREADY  <= 1'b1;
              PSLVERR <= cur_err;
              if (!cur_wr && !cur_err) PRDATA <= mem[cur_idx];
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (!sel || !PENABLE) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state   <= S_READY;
            PREADY  <= 1'b1;
            PSLVERR <= cur_err;
            if (!cur_wr && !cur_err) PRDATA <= mem[cur_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_READY: begin
          if (wr && !err && sel && PENABLE) mem[idx] <= wdata;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: three completers on one APB bus, each with its own select
// bit and wait-state count, checked against an array model.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        hreset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int          checks   = 0;
  int          failures = 0;
  int          ws [3]   = '{1, 0, 3};
  logic [31:0] model [3][16];

  always #5 clk = ~clk;

  apb_slave_regfile #(.SLAVE_SEL(0), .BASE_ADDR(BASE), .DEPTH(16),
    .WAIT_STATES(1)) u0 (
    .HCLK(clk), .HRESET(hreset), .PSELX(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.SLAVE_SEL(1), .BASE_ADDR(BASE), .DEPTH(16),
    .WAIT_STATES(0)) u1 (
    .HCLK(clk), .HRESET(hreset), .PSELX(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_regfile #(.SLAVE_SEL(2), .BASE_ADDR(BASE), .DEPTH(16),
    .WAIT_STATES(3)) u2 (
    .HCLK(clk), .HRESET(hreset), .PSELX(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) model[k][i] = '0;
  endtask

  task automatic idle(input int n);
    psel    = 3'b000;
    penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // full APB transfer to completer k; returns one cycle after completion
  task automatic xfer(input int k, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        done;
    int          n;
    int          noisy;
    exp_err = (addr[1:0] != 2'b00) || (addr < BASE) ||
              (addr > BASE + 32'h3F);
    exp_rd  = (!wr && !exp_err) ? model[k][addr[5:2]] : 32'h0;
    psel    = 3'(1 << k);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(posedge clk);
    #1;
    penable = 1'b1;
    pwdata  = ~wd;
    n = 0;
    done = 1'b0;
    noisy = 0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
      for (int j = 0; j < 3; j++)
        if (j != k && pready[j] !== 1'b0) noisy++;
      if (pready[k] === 1'b1) begin
        done = 1'b1;
        check("prdata", prdata[k], exp_rd);
        check("pslverr", 32'(pslverr[k]), 32'(exp_err));
      end
      @(posedge clk);
      #1;
    end
    check("access_cycles", 32'(n), 32'(ws[k] + 1));
    check("unselected_quiet", 32'(noisy), 32'd0);
    if (wr && !exp_err) model[k][addr[5:2]] = wd;
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_prdata"}, prdata[k], 32'h0);
      check({tag, "_pready"}, 32'(pready[k]), 32'h0);
      check({tag, "_pslverr"}, 32'(pslverr[k]), 32'h0);
    end
  endtask

  initial begin
    int          k;
    int          r;
    int          hits;
    logic [31:0] a;
    hreset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    hreset = 1'b0;
    idle(1);

    xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0);
    xfer(1, 1'b0, 32'h8000_0008, 32'h0);

    xfer(1, 1'b1, 32'h8000_0000, 32'hA5A5_0001);
    xfer(1, 1'b1, 32'h8000_003C, 32'h5A5A_003C);
    xfer(1, 1'b0, 32'h8000_0000, 32'h0);
    xfer(1, 1'b0, 32'h8000_003C, 32'h0);
    idle(1);

    xfer(0, 1'b1, 32'h8000_0004, 32'h0BAD_F00D);
    xfer(0, 1'b0, 32'h8000_0040, 32'h0);
    xfer(0, 1'b1, 32'h8000_0006, 32'hFFFF_FFFF);
    xfer(0, 1'b0, 32'h8000_0004, 32'h0);
    idle(1);

    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h8000_0010;
    pwdata  = 32'h1234_5678;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel    = 3'b000;
    penable = 1'b0;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready[2] !== 1'b0) hits++;
    end
    check("abort_no_ready", 32'(hits), 32'd0);
    @(posedge clk);
    #1;
    xfer(2, 1'b0, 32'h8000_0010, 32'h0);
    idle(1);

    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, 15)) * 4;
      if (r == 7) a = a + 32'($urandom_range(1, 3));
      if (r == 8) a = a + 32'h40 * 32'($urandom_range(1, 8));
      if (r == 9) a = $urandom & 32'hFFFF_FFFC;
      xfer(k, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h8000_000C;
    pwdata  = 32'hCAFE_0003;
    @(posedge clk);
    #1;
    penable = 1'b1;
    hreset  = 1'b1;
    @(posedge clk);
    #1;
    hreset  = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    check_outputs_zero("midop_reset");
    clear_model();
    idle(1);
    for (int i = 0; i < 16; i++)
      xfer(0, 1'b0, BASE + 32'(i) * 4, 32'h0);
    xfer(2, 1'b0, 32'h8000_003C, 32'h0);
    xfer(0, 1'b1, 32'h8000_000C, 32'h7777_1111);
    xfer(0, 1'b0, 32'h8000_000C, 32'h0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB responder (completer) at the far end of the AHB-to-APB bridge path.
- Decodes one bit of the bridge's 3-bit one-hot peripheral select and serves APB setup/access transfers against an internal word-addressed register file.
- Inserts a programmable number of wait states and flags bad addresses with PSLVERR.
- Gives the bridge and AHB master a real peripheral to read and write, replacing the pass-through APB model in top-level simulation.

Parameters:
- SLAVE_SEL, 0: index of the PSELX bit this instance responds to (0..2).
- BASE_ADDR, 32'h8000_0000: byte base address of the register window; must be aligned to DEPTH*4.
- DEPTH, 16: number of 32-bit registers; power of two, 2..256; AW = log2(DEPTH).
- WAIT_STATES, 1: access-phase wait cycles before PREADY (0..15).

Ports:
- HCLK  input  1  system clock; all logic on the rising edge.
- HRESET  input  1  synchronous active-high reset.
- PSELX  input  3  one-hot peripheral select from the bridge.
- PENABLE  input  1  APB access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data; valid only while PREADY=1.
- PREADY  output  1  transfer completes in the current cycle.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Internal select: sel = PSELX[SLAVE_SEL]. Other PSELX bits are ignored.
- Reset (HRESET=1 at a rising edge):
  - state=IDLE; wait counter=0; all DEPTH registers=0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - A reset during WAIT or READY aborts the transfer and performs no write.
- All outputs are registered. Outside the READY state: PREADY=0, PSLVERR=0, PRDATA=0.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - Setup is detected when sel=1 and PENABLE=0.
  - At that edge, capture PADDR, PWRITE and PWDATA.
  - Compute err = (PADDR[1:0]!=0) or (PADDR[31:AW+2] != BASE_ADDR[31:AW+2]).
  - If WAIT_STATES=0: go to READY. Otherwise go to WAIT with cnt=WAIT_STATES.
  - PENABLE=1 seen in IDLE with no preceding setup: ignored, no response.
- WAIT:
  - PREADY=0 for exactly WAIT_STATES cycles.
  - Each edge: if sel=0 or PENABLE=0, abort to IDLE with no write. Else if cnt=1, go to READY. Else decrement cnt.
- Entering READY, registered at the same edge as the transition:
  - PREADY=1; PSLVERR=err.
  - PRDATA = (read and !err) ? reg[captured_addr[AW+1:2]] : 0.
  - Write transfers drive PRDATA=0.
- READY:
  - Lasts one cycle; always returns to IDLE at the next edge.
  - Write commit: at that edge, if captured write, !err, sel=1 and PENABLE=1, then reg[idx] <= captured PWDATA.
  - If sel or PENABLE dropped during READY: no write, return to IDLE.
- Latency: the access phase is WAIT_STATES+1 cycles. The setup→completion edge distance is WAIT_STATES+2.
- Back-to-back transfers: a setup in the cycle immediately after READY is accepted normally. No idle cycle is required.
- Write data is taken from the setup-cycle capture. PWDATA changing in the access phase has no effect.
- Error transfers never modify any register. Read-after-write to the same index returns the new value.
- Address wrap: none. Any address outside [BASE_ADDR, BASE_ADDR+DEPTH*4-1] is an error.

Test Plan:
- Write/read, defaults: write 32'hDEAD_BEEF to 32'h8000_0008, then read 32'h8000_0008.
  - Each access phase is 2 cycles, with PREADY=1 in the 2nd.
  - Read returns PRDATA=32'hDEAD_BEEF with PSLVERR=0.
- Zero wait (WAIT_STATES=0): back-to-back writes to 0x0 and 0x3C, then reads with no idle cycles between transfers.
  - PREADY=1 in the first access cycle of every transfer.
  - Reads return the written data.
- Errors:
  - Read 32'h8000_0040 → PREADY=1, PSLVERR=1, PRDATA=0.
  - Write 32'h8000_0006 (misaligned) → PSLVERR=1; a subsequent read of 0x4 returns the old value.
- Select mismatch: with SLAVE_SEL=0, run a transfer with PSELX=3'b010 → PREADY stays 0 and no register changes.
- Abort: WAIT_STATES=3; deassert PSELX after the 1st wait cycle of a write of 32'h1234_5678 to 0x10.
  - State returns to IDLE and PREADY never asserts.
  - A later read of 0x10 returns 0.
- Reset mid-op: assert HRESET during the WAIT of a write.
  - Next cycle all outputs are 0.
  - Reads of every index return 0; a fresh transfer completes normally.
